// File: rtl/pipe_pkg.sv
// Shared encodings for the fetch-PC redirect logic: sequencer states,
// redirect priority codes and the machine-external-interrupt mcause value.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // Numeric order is the arbitration order: a larger code wins.
  typedef enum logic [2:0] {
    PRIO_NONE = 3'd0,
    PRIO_BR   = 3'd1,
    PRIO_IRQ  = 3'd2,
    PRIO_MRET = 3'd3,
    PRIO_EXC  = 3'd4
  } prio_e;

  localparam logic [31:0] MCAUSE_MEI = 32'h8000_000B;

  function automatic logic prio_higher(input prio_e a, input prio_e b);
    return (a > b);
  endfunction

endpackage

// File: rtl/redirect_arb.sv
// Combinational priority pick among exception, mret, interrupt and branch
// redirects; also produces the mcause/mepc values for a trap.
module redirect_arb
  import pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            exc_valid_i,
  input  logic [4:0]      exc_cause_i,
  input  logic [XLEN-1:0] exc_pc_i,
  input  logic            mret_valid_i,
  input  logic [XLEN-1:0] mepc_i,
  input  logic [XLEN-1:0] mtvec_i,
  input  logic            irq_req_i,
  input  logic            br_valid_i,
  input  logic [XLEN-1:0] br_target_i,
  input  logic [XLEN-1:0] irq_fallback_pc_i,
  output logic            ev_valid_o,
  output prio_e           ev_prio_o,
  output logic [XLEN-1:0] ev_target_o,
  output logic            ev_trap_o,
  output logic [31:0]     ev_cause_o,
  output logic [XLEN-1:0] ev_epc_o
);

  logic [XLEN-1:0] trap_base;
  assign trap_base = mtvec_i & ~XLEN'(3);

  always_comb begin
    ev_valid_o  = 1'b0;
    ev_prio_o   = PRIO_NONE;
    ev_target_o = '0;
    ev_trap_o   = 1'b0;
    ev_cause_o  = '0;
    ev_epc_o    = '0;
    if (exc_valid_i) begin
      ev_valid_o  = 1'b1;
      ev_prio_o   = PRIO_EXC;
      ev_target_o = trap_base;
      ev_trap_o   = 1'b1;
      ev_cause_o  = {27'b0, exc_cause_i};
      ev_epc_o    = exc_pc_i;
    end else if (mret_valid_i) begin
      ev_valid_o  = 1'b1;
      ev_prio_o   = PRIO_MRET;
      ev_target_o = mepc_i;
    end else if (irq_req_i) begin
      // The interrupted stream resumes where fetch would have gone next.
      ev_valid_o  = 1'b1;
      ev_prio_o   = PRIO_IRQ;
      ev_target_o = trap_base;
      ev_trap_o   = 1'b1;
      ev_cause_o  = MCAUSE_MEI;
      ev_epc_o    = br_valid_i ? br_target_i : irq_fallback_pc_i;
    end else if (br_valid_i) begin
      ev_valid_o  = 1'b1;
      ev_prio_o   = PRIO_BR;
      ev_target_o = br_target_i;
    end
  end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Fetch-PC sequencer: chooses the PC register's next value each cycle,
// parks redirects while IF is stalled and signals trap entry to the CSRs.
module pc_redirect_ctrl
  import pipe_pkg::*;
#(
  parameter logic [31:0] BOOT_PC = 32'h0000_0000,
  parameter int          XLEN    = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc_cur,
  input  logic            if_allow_in,
  input  logic            br_valid,
  input  logic [XLEN-1:0] br_target,
  input  logic            exc_valid,
  input  logic [4:0]      exc_cause,
  input  logic [XLEN-1:0] exc_pc,
  input  logic            mret_valid,
  input  logic [XLEN-1:0] mepc,
  input  logic [XLEN-1:0] mtvec,
  input  logic            irq_pending,
  input  logic            irq_enable,
  output logic [XLEN-1:0] next_pc,
  output logic            pre_if_valid,
  output logic            flush,
  output logic            trap_taken,
  output logic [31:0]     trap_cause,
  output logic [XLEN-1:0] trap_epc
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;
  prio_e           pend_prio_q, pend_prio_d;
  logic            irq_block_q;

  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] irq_fallback_pc;
  logic            irq_req;
  logic            ev_valid;
  prio_e           ev_prio;
  logic [XLEN-1:0] ev_target;
  logic            ev_trap;
  logic [31:0]     ev_cause;
  logic [XLEN-1:0] ev_epc;
  logic            accept;

  assign seq_pc  = pc_cur + XLEN'(4);
  // MIE is still set in the cycle after trap entry; suppress re-entry there.
  assign irq_req = irq_pending & irq_enable & ~irq_block_q;
  assign irq_fallback_pc = (state_q == ST_HOLD && pend_prio_q == PRIO_BR) ? pend_pc_q : seq_pc;

  redirect_arb #(.XLEN(XLEN)) u_arb (
    .exc_valid_i       (exc_valid),
    .exc_cause_i       (exc_cause),
    .exc_pc_i          (exc_pc),
    .mret_valid_i      (mret_valid),
    .mepc_i            (mepc),
    .mtvec_i           (mtvec),
    .irq_req_i         (irq_req),
    .br_valid_i        (br_valid),
    .br_target_i       (br_target),
    .irq_fallback_pc_i (irq_fallback_pc),
    .ev_valid_o        (ev_valid),
    .ev_prio_o         (ev_prio),
    .ev_target_o       (ev_target),
    .ev_trap_o         (ev_trap),
    .ev_cause_o        (ev_cause),
    .ev_epc_o          (ev_epc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_BOOT;
      pend_pc_q   <= '0;
      pend_prio_q <= PRIO_NONE;
      irq_block_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_pc_q   <= pend_pc_d;
      pend_prio_q <= pend_prio_d;
      irq_block_q <= trap_taken;
    end
  end

  always_comb begin
    state_d      = state_q;
    pend_pc_d    = pend_pc_q;
    pend_prio_d  = pend_prio_q;
    accept       = 1'b0;
    next_pc      = seq_pc;
    pre_if_valid = 1'b1;
    flush        = 1'b0;
    trap_taken   = 1'b0;
    trap_cause   = '0;
    trap_epc     = '0;

    unique case (state_q)
      ST_BOOT: begin
        next_pc = BOOT_PC;
        if (if_allow_in) state_d = ST_RUN;
      end
      ST_RUN: begin
        accept = ev_valid;
        if (ev_valid) begin
          next_pc = ev_target;
          if (!if_allow_in) begin
            pend_pc_d   = ev_target;
            pend_prio_d = ev_prio;
            state_d     = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        next_pc = pend_pc_q;
        accept  = ev_valid && prio_higher(ev_prio, pend_prio_q);
        if (accept) begin
          next_pc     = ev_target;
          pend_pc_d   = ev_target;
          pend_prio_d = ev_prio;
        end
        if (if_allow_in) begin
          state_d     = ST_RUN;
          pend_prio_d = PRIO_NONE;
        end
      end
      default: begin
        state_d = ST_BOOT;
        next_pc = BOOT_PC;
      end
    endcase

    if (accept) begin
      flush      = 1'b1;
      trap_taken = ev_trap;
      trap_cause = ev_trap ? ev_cause : '0;
      trap_epc   = ev_trap ? ev_epc : '0;
    end

    // Hold the documented reset values on the outputs while reset is asserted.
    if (!rst_n) begin
      state_d      = ST_BOOT;
      pend_pc_d    = '0;
      pend_prio_d  = PRIO_NONE;
      next_pc      = BOOT_PC;
      pre_if_valid = 1'b1;
      flush        = 1'b0;
      trap_taken   = 1'b0;
      trap_cause   = '0;
      trap_epc     = '0;
    end
  end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench for pc_redirect_ctrl: hand-computed expectations checked
// at the falling edge after inputs settle.
module tb_pc_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_cur;
  logic        if_allow_in;
  logic        br_valid;
  logic [31:0] br_target;
  logic        exc_valid;
  logic [4:0]  exc_cause;
  logic [31:0] exc_pc;
  logic        mret_valid;
  logic [31:0] mepc;
  logic [31:0] mtvec;
  logic        irq_pending;
  logic        irq_enable;
  logic [31:0] next_pc;
  logic        pre_if_valid;
  logic        flush;
  logic        trap_taken;
  logic [31:0] trap_cause;
  logic [31:0] trap_epc;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pc_redirect_ctrl #(.BOOT_PC(32'h0000_0000), .XLEN(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pc_cur       (pc_cur),
    .if_allow_in  (if_allow_in),
    .br_valid     (br_valid),
    .br_target    (br_target),
    .exc_valid    (exc_valid),
    .exc_cause    (exc_cause),
    .exc_pc       (exc_pc),
    .mret_valid   (mret_valid),
    .mepc         (mepc),
    .mtvec        (mtvec),
    .irq_pending  (irq_pending),
    .irq_enable   (irq_enable),
    .next_pc      (next_pc),
    .pre_if_valid (pre_if_valid),
    .flush        (flush),
    .trap_taken   (trap_taken),
    .trap_cause   (trap_cause),
    .trap_epc     (trap_epc)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  // Advance to just after the next rising edge, clearing pulse inputs.
  task automatic cyc();
    @(posedge clk);
    #1;
    br_valid   = 1'b0;
    exc_valid  = 1'b0;
    mret_valid = 1'b0;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Convenience: check the four most common outputs of a cycle.
  task automatic expect4(input string tag, input logic [31:0] npc, input logic fl,
                         input logic tt, input logic [31:0] cause);
    sample();
    check({tag, ".next_pc"}, next_pc, npc);
    check({tag, ".flush"}, {31'b0, flush}, {31'b0, fl});
    check({tag, ".trap_taken"}, {31'b0, trap_taken}, {31'b0, tt});
    check({tag, ".trap_cause"}, trap_cause, cause);
  endtask

  initial begin
    rst_n = 1'b0; pc_cur = '0; if_allow_in = 1'b0;
    br_valid = 1'b0; br_target = '0; exc_valid = 1'b0; exc_cause = '0; exc_pc = '0;
    mret_valid = 1'b0; mepc = '0; mtvec = 32'h0000_1001; irq_pending = 1'b0; irq_enable = 1'b0;

    // Reset values
    cyc();
    sample();
    check("rst.next_pc", next_pc, 32'h0);
    check("rst.pre_if_valid", {31'b0, pre_if_valid}, 32'h1);
    check("rst.flush", {31'b0, flush}, 32'h0);
    check("rst.trap_taken", {31'b0, trap_taken}, 32'h0);
    check("rst.trap_cause", trap_cause, 32'h0);
    check("rst.trap_epc", trap_epc, 32'h0);
    cyc();
    rst_n = 1'b1;

    // Boot then sequential fetch
    if_allow_in = 1'b1;
    expect4("boot0", 32'h0, 1'b0, 1'b0, 32'h0);
    cyc(); pc_cur = 32'h0;
    expect4("seq4", 32'h4, 1'b0, 1'b0, 32'h0);
    check("seq4.pre_if_valid", {31'b0, pre_if_valid}, 32'h1);
    cyc(); pc_cur = 32'h4;
    expect4("seq8", 32'h8, 1'b0, 1'b0, 32'h0);

    // Same-cycle branch redirect
    cyc(); pc_cur = 32'h100; br_valid = 1'b1; br_target = 32'h200;
    expect4("br_direct", 32'h200, 1'b1, 1'b0, 32'h0);

    // Branch parked while IF stalled, held, then released
    cyc(); pc_cur = 32'h200; br_valid = 1'b1; br_target = 32'h300; if_allow_in = 1'b0;
    expect4("br_park", 32'h300, 1'b1, 1'b0, 32'h0);
    cyc();
    expect4("hold1", 32'h300, 1'b0, 1'b0, 32'h0);
    cyc(); if_allow_in = 1'b1;
    expect4("hold_rel", 32'h300, 1'b0, 1'b0, 32'h0);
    cyc(); pc_cur = 32'h300;
    expect4("after_rel", 32'h304, 1'b0, 1'b0, 32'h0);

    // Exception overrides a parked branch; later branch in HOLD ignored
    cyc(); pc_cur = 32'h304; br_valid = 1'b1; br_target = 32'h300; if_allow_in = 1'b0;
    expect4("br_park2", 32'h300, 1'b1, 1'b0, 32'h0);
    cyc(); exc_valid = 1'b1; exc_pc = 32'h40; exc_cause = 5'd2;
    expect4("exc_in_hold", 32'h1000, 1'b1, 1'b1, 32'h2);
    check("exc_in_hold.trap_epc", trap_epc, 32'h40);
    cyc(); br_valid = 1'b1; br_target = 32'h700;
    expect4("br_ignored", 32'h1000, 1'b0, 1'b0, 32'h0);
    cyc(); if_allow_in = 1'b1;
    expect4("exc_rel", 32'h1000, 1'b0, 1'b0, 32'h0);

    // Interrupt beats a same-cycle branch; epc is the branch target
    cyc(); pc_cur = 32'h1000; irq_pending = 1'b1; irq_enable = 1'b1;
    br_valid = 1'b1; br_target = 32'h500;
    expect4("irq_br", 32'h1000, 1'b1, 1'b1, 32'h8000_000B);
    check("irq_br.trap_epc", trap_epc, 32'h500);
    cyc(); pc_cur = 32'h1000;
    expect4("irq_block", 32'h1004, 1'b0, 1'b0, 32'h0);
    irq_pending = 1'b0;

    // Interrupt while a branch is parked: epc is the parked target
    cyc(); pc_cur = 32'h1004; br_valid = 1'b1; br_target = 32'h600; if_allow_in = 1'b0;
    expect4("br_park3", 32'h600, 1'b1, 1'b0, 32'h0);
    cyc(); irq_pending = 1'b1;
    expect4("irq_hold", 32'h1000, 1'b1, 1'b1, 32'h8000_000B);
    check("irq_hold.trap_epc", trap_epc, 32'h600);
    cyc(); irq_pending = 1'b0; if_allow_in = 1'b1;
    expect4("irq_hold_rel", 32'h1000, 1'b0, 1'b0, 32'h0);

    // Exception beats mret; then mret alone
    cyc(); pc_cur = 32'h1000; mret_valid = 1'b1; mepc = 32'h500;
    exc_valid = 1'b1; exc_cause = 5'd3; exc_pc = 32'h44;
    expect4("exc_vs_mret", 32'h1000, 1'b1, 1'b1, 32'h3);
    check("exc_vs_mret.trap_epc", trap_epc, 32'h44);
    cyc(); mret_valid = 1'b1;
    expect4("mret", 32'h500, 1'b1, 1'b0, 32'h0);

    // Misaligned target passes through unchanged
    cyc(); pc_cur = 32'h500; br_valid = 1'b1; br_target = 32'h202;
    expect4("misaligned", 32'h202, 1'b1, 1'b0, 32'h0);

    // Reset mid-HOLD discards the parked redirect; events in BOOT ignored
    cyc(); pc_cur = 32'h202; br_valid = 1'b1; br_target = 32'h800; if_allow_in = 1'b0;
    expect4("br_park4", 32'h800, 1'b1, 1'b0, 32'h0);
    cyc(); rst_n = 1'b0;
    cyc(); rst_n = 1'b1; br_valid = 1'b1; br_target = 32'h900;
    expect4("boot_ignore", 32'h0, 1'b0, 1'b0, 32'h0);
    cyc(); if_allow_in = 1'b1;
    expect4("boot_rel", 32'h0, 1'b0, 1'b0, 32'h0);
    cyc(); pc_cur = 32'h0;
    expect4("boot_seq", 32'h4, 1'b0, 1'b0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_redirect_ctrl.md
Name: pc_redirect_ctrl

Overview:
- Sequencer for the fetch PC register in the pipelined RV32I core with exceptions and interrupts.
- Each cycle it selects the PC register's next value (din) and its load qualifier (pre_if_valid).
- Arbitrates boot, trap, mret, interrupt, branch/jump and sequential sources.
- Parks a redirect that arrives while IF is stalled, flushes the wrong path and reports trap entry to the CSR unit.

Parameters:
- BOOT_PC, 32'h0000_0000, first fetch address after reset.
- XLEN, 32, datapath width. Only 32 is supported.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- pc_cur  in  32  current PC register value
- if_allow_in  in  1  IF stage accepts a new PC this cycle
- br_valid  in  1  EX resolved taken branch/jump (1-cycle pulse)
- br_target  in  32  branch/jump target
- exc_valid  in  1  synchronous exception at commit (pulse)
- exc_cause  in  5  exception cause code
- exc_pc  in  32  PC of the faulting instruction
- mret_valid  in  1  mret at commit (pulse)
- mepc  in  32  CSR mepc
- mtvec  in  32  CSR mtvec (direct mode only)
- irq_pending  in  1  level, any enabled interrupt pending
- irq_enable  in  1  mstatus.MIE
- next_pc  out  32  din for the PC register
- pre_if_valid  out  1  load strobe for the PC register
- flush  out  1  kill IF/ID/EX wrong-path instructions
- trap_taken  out  1  1-cycle pulse: CSR unit writes mepc/mcause and clears MIE
- trap_cause  out  32  mcause value (bit31 = interrupt)
- trap_epc  out  32  value for mepc

Behaviour:
- State machine:
  - BOOT: next_pc=BOOT_PC, pre_if_valid=1. Go to RUN when if_allow_in=1.
  - RUN: no redirect parked. next_pc = selected redirect target, else pc_cur+4 (mod 2^32). pre_if_valid=1.
  - HOLD: a redirect is parked in pend_pc. next_pc=pend_pc, pre_if_valid=1. Go to RUN when if_allow_in=1.
- Source priority, highest first: exc_valid > mret_valid > irq (irq_pending & irq_enable) > br_valid > sequential. Lower sources in the same cycle are discarded.
- Targets:
  - exception and interrupt: {mtvec[31:2],2'b00}
  - mret: mepc
  - branch: br_target
- A redirect event in RUN:
  - if_allow_in=1: target is driven onto next_pc the same cycle (0 latency); stay in RUN.
  - if_allow_in=0: target is latched into pend_pc; go to HOLD.
- New event while in HOLD:
  - Strictly higher priority than the parked one: overwrites pend_pc. It is driven the same cycle if if_allow_in=1.
  - Equal or lower priority: ignored; no flush and no trap pulse.
- Parked priority is stored as a 3-bit code.
- Events arriving in BOOT are ignored.
- flush=1 combinationally in every cycle an event is accepted, whether driven directly or parked.
- trap_taken=1 in the cycle an exception or interrupt is accepted.
  - Exception: trap_cause={27'b0,exc_cause}, trap_epc=exc_pc.
  - Interrupt: trap_cause=32'h8000_000B (machine external), trap_epc = address that would otherwise have been fetched: br_target if br_valid that cycle, else pend_pc if HOLD holds a branch, else pc_cur+4.
- Interrupt is not accepted in the cycle after trap_taken, to avoid re-entry before MIE clears.
- Misaligned targets (bits[1:0] != 0) are passed through unmodified. Alignment faults are raised by IF, not here.
- Reset values: state=BOOT, pend_pc=0, pend_prio=0, next_pc=BOOT_PC, pre_if_valid=1, flush=0, trap_taken=0, trap_cause=0, trap_epc=0.
- Reset mid-HOLD discards the parked redirect.

Decomposition:
- Shared package pipe_pkg holds:
  - state encodings (BOOT/RUN/HOLD)
  - priority codes (PRIO_NONE, PRIO_BR, PRIO_IRQ, PRIO_MRET, PRIO_EXC)
  - MCAUSE_MEI constant, 32'h8000_000B
- Sub-module redirect_arb: purely combinational priority selection producing target, priority and trap info.
- The FSM and pend registers stay in pc_redirect_ctrl.

Test Plan:
- Reset, then if_allow_in=1 for 3 cycles -> next_pc 0x0, 0x4, 0x8 with pc_cur tracking; pre_if_valid=1 throughout.
- pc_cur=0x100, br_valid with br_target=0x200, if_allow_in=1 -> same-cycle next_pc=0x200, flush=1, no trap_taken.
- br_valid with target 0x300 while if_allow_in=0 for 2 cycles -> state HOLD, next_pc=0x300 held; release -> RUN, next cycle next_pc = pc_cur+4.
- HOLD with branch 0x300, then exc_valid (exc_pc=0x40, cause=2, mtvec=0x1001) -> pend_pc=0x1000, trap_taken=1, trap_cause=2, trap_epc=0x40. A later br_valid while still in HOLD is ignored.
- irq_pending=1, irq_enable=1, br_valid target 0x500 in the same cycle -> next_pc=mtvec base, trap_cause=0x8000000B, trap_epc=0x500. irq_pending held high the next cycle -> no second trap_taken.
- mret_valid with mepc=0x500 and exc_valid in the same cycle -> exception wins. mret alone -> next_pc=0x500, flush=1, trap_taken=0.
